// File: rtl/seq_check_pkg.sv
// Shared encodings and sequence tables for the repeating-sequence counter checker.
// Tables are indexed by the current value; illegal entries map to 0.
package seq_check_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic MODE_A = 1'b0;
    localparam logic MODE_B = 1'b1;

    // Sequence A: 0 -> 4 -> 7 -> 2 -> 3 -> 0, entries listed from value 7 down to value 0
    localparam logic [7:0][2:0] SEQ_A_NEXT  = {3'd2, 3'd0, 3'd0, 3'd7, 3'd0, 3'd3, 3'd0, 3'd4};
    localparam logic [7:0]      SEQ_A_LEGAL = 8'b1001_1101;

    // Sequence B: 0 -> 2 -> 4 -> 6 -> 0
    localparam logic [7:0][2:0] SEQ_B_NEXT  = {3'd0, 3'd0, 3'd0, 3'd6, 3'd0, 3'd4, 3'd0, 3'd2};
    localparam logic [7:0]      SEQ_B_LEGAL = 8'b0101_0101;

endpackage

// File: rtl/seq_next_lut.sv
// Combinational successor lookup for the counter sequences.
// Gives the next value in the selected sequence and whether v is part of it.
module seq_next_lut
    import seq_check_pkg::*;
(
    input  logic       mode,
    input  logic [2:0] v,
    output logic [2:0] nxt,
    output logic       legal
);

    always_comb begin
        nxt   = '0;
        legal = 1'b0;
        if (mode == MODE_B) begin
            nxt   = SEQ_B_NEXT[v];
            legal = SEQ_B_LEGAL[v];
        end else begin
            nxt   = SEQ_A_NEXT[v];
            legal = SEQ_A_LEGAL[v];
        end
    end

endmodule

// File: rtl/seq_checker.sv
// Sequence checker: locks onto a cyclic counter stream and counts breaks while locked.
// All outputs are registered; a mode change forces re-acquisition and ignores that sample.
module seq_checker
    import seq_check_pkg::*;
#(
    parameter int unsigned LOCK_COUNT = 3,
    parameter int unsigned ERR_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_en,
    input  logic [2:0]       q,
    input  logic             mode,
    input  logic             clr_err,
    output logic             locked,
    output logic             seq_err,
    output logic [ERR_W-1:0] err_count,
    output logic [2:0]       expected
);

    localparam int unsigned CW = $clog2(LOCK_COUNT + 1);
    localparam logic [CW-1:0] LAST_MATCH = CW'(LOCK_COUNT - 1);

    state_t        state;
    logic [CW-1:0] match_cnt;
    logic          mode_q;
    logic [2:0]    nxt;
    logic          legal;
    logic          hit;
    logic          mode_change;
    logic          err_inc;

    seq_next_lut u_lut (
        .mode  (mode),
        .v     (q),
        .nxt   (nxt),
        .legal (legal)
    );

    always_comb begin
        hit         = (q == expected);
        mode_change = (mode != mode_q);
        err_inc     = !mode_change && sample_en && (state == LOCKED) && !hit;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= HUNT;
            match_cnt <= '0;
            mode_q    <= MODE_A;
            locked    <= 1'b0;
            seq_err   <= 1'b0;
            err_count <= '0;
            expected  <= '0;
        end else begin
            mode_q  <= mode;
            seq_err <= 1'b0;

            // A break coinciding with a clear leaves one count so it is not lost
            if (clr_err)
                err_count <= err_inc ? ERR_W'(1) : '0;
            else if (err_inc && (err_count != '1))
                err_count <= err_count + ERR_W'(1);

            if (mode_change) begin
                state     <= HUNT;
                locked    <= 1'b0;
                expected  <= '0;
                match_cnt <= '0;
            end else if (sample_en) begin
                case (state)
                    HUNT: begin
                        if (legal) begin
                            expected  <= nxt;
                            match_cnt <= '0;
                            state     <= VERIFY;
                        end
                    end
                    VERIFY: begin
                        expected <= nxt;
                        if (hit) begin
                            match_cnt <= match_cnt + CW'(1);
                            if (match_cnt == LAST_MATCH) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            match_cnt <= '0;
                            state     <= legal ? VERIFY : HUNT;
                        end
                    end
                    LOCKED: begin
                        expected <= nxt;
                        if (!hit) begin
                            seq_err   <= 1'b1;
                            locked    <= 1'b0;
                            match_cnt <= '0;
                            state     <= legal ? VERIFY : HUNT;
                        end
                    end
                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seq_checker.sv
// Directed bench for seq_checker with hand-computed expectations.
module tb_seq_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       sample_en;
    logic [2:0] q;
    logic       mode;
    logic       clr_err;
    logic       locked;
    logic       seq_err;
    logic [1:0] err_count;
    logic [2:0] expected;

    int unsigned errors = 0;
    int unsigned checks = 0;

    seq_checker #(.LOCK_COUNT(3), .ERR_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .sample_en (sample_en),
        .q         (q),
        .mode      (mode),
        .clr_err   (clr_err),
        .locked    (locked),
        .seq_err   (seq_err),
        .err_count (err_count),
        .expected  (expected)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] next_a(input logic [2:0] v);
        case (v)
            3'd0: return 3'd4;
            3'd4: return 3'd7;
            3'd7: return 3'd2;
            3'd2: return 3'd3;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [2:0] next_b(input logic [2:0] v);
        case (v)
            3'd0: return 3'd2;
            3'd2: return 3'd4;
            3'd4: return 3'd6;
            default: return 3'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input logic [2:0] v);
        q = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] cur;
        logic [2:0] bad;
        logic [1:0] cnt_model;

        reset = 1'b0; sample_en = 1'b1; q = 3'd0; mode = 1'b0; clr_err = 1'b0;
        #1;
        check("rst_locked", 32'(locked), 0);
        check("rst_seq_err", 32'(seq_err), 0);
        check("rst_err_count", 32'(err_count), 0);
        check("rst_expected", 32'(expected), 0);
        #1 reset = 1'b1;

        // Mode A lock acquisition
        tick(3'd0); check("a_acq_exp", 32'(expected), 4); check("a_acq_lock", 32'(locked), 0);
        tick(3'd4); check("a_m1_exp", 32'(expected), 7);
        tick(3'd7); check("a_m2_lock", 32'(locked), 0);
        tick(3'd2); check("a_lock", 32'(locked), 1); check("a_lock_exp", 32'(expected), 3);

        cur = 3'd3;
        for (int i = 0; i < 20; i++) begin
            tick(cur);
            cur = next_a(cur);
            check("a_run_exp", 32'(expected), 32'(cur));
            check("a_run_err", 32'({seq_err, locked, err_count}), 32'b0100);
        end

        // Sample enable low: garbage q ignored, everything holds
        sample_en = 1'b0;
        for (int i = 0; i < 3; i++) tick(3'd5);
        check("hold_lock", 32'(locked), 1);
        check("hold_exp", 32'(expected), 32'(cur));
        check("hold_seq_err", 32'(seq_err), 0);
        sample_en = 1'b1;
        tick(cur); cur = next_a(cur);
        check("hold_resume", 32'({locked, expected}), 32'({1'b1, cur}));

        // Mode flip to B while locked
        mode = 1'b1;
        tick(cur);
        check("flip_lock", 32'(locked), 0);
        check("flip_seq_err", 32'(seq_err), 0);
        check("flip_err_count", 32'(err_count), 0);
        check("flip_exp", 32'(expected), 0);
        tick(3'd0); check("b_acq_exp", 32'(expected), 2);
        tick(3'd2);
        tick(3'd4); check("b_m2_lock", 32'(locked), 0);
        tick(3'd6); check("b_lock", 32'(locked), 1); check("b_lock_exp", 32'(expected), 0);

        // Break in mode B: 2 where 6 expected
        tick(3'd0); tick(3'd2); tick(3'd4);
        tick(3'd2);
        check("b_brk_seq_err", 32'(seq_err), 1);
        check("b_brk_count", 32'(err_count), 1);
        check("b_brk_lock", 32'(locked), 0);
        check("b_brk_exp", 32'(expected), 4);
        tick(3'd4); check("b_pulse_once", 32'(seq_err), 0);
        tick(3'd6); check("b_relock_pre", 32'(locked), 0);
        tick(3'd0); check("b_relock", 32'(locked), 1);

        // Repeated breaks to saturate the 2-bit counter
        cur = 3'd2;
        cnt_model = 2'd1;
        for (int i = 0; i < 5; i++) begin
            bad = cur + 3'd2;
            tick(bad);
            if (cnt_model != 2'd3) cnt_model = cnt_model + 2'd1;
            check("sat_seq_err", 32'(seq_err), 1);
            check("sat_count", 32'(err_count), 32'(cnt_model));
            cur = next_b(bad);
            for (int k = 0; k < 3; k++) begin
                tick(cur);
                cur = next_b(cur);
            end
            check("sat_relock", 32'(locked), 1);
        end
        check("sat_final", 32'(err_count), 3);

        // Clear together with a break keeps the new error
        clr_err = 1'b1;
        tick(cur + 3'd2);
        clr_err = 1'b0;
        check("clr_brk_count", 32'(err_count), 1);
        check("clr_brk_seq_err", 32'(seq_err), 1);
        sample_en = 1'b0; clr_err = 1'b1;
        tick(3'd0);
        sample_en = 1'b1; clr_err = 1'b0;
        check("clr_only", 32'(err_count), 0);

        // Illegal stream in mode A stays hunting
        mode = 1'b0;
        tick(3'd0);
        check("ill_flip_lock", 32'(locked), 0);
        tick(3'd5); tick(3'd6); tick(3'd1); tick(3'd5);
        check("ill_lock", 32'(locked), 0);
        check("ill_exp", 32'(expected), 0);
        check("ill_seq_err", 32'(seq_err), 0);
        tick(3'd0); check("ill_acq_exp", 32'(expected), 4);
        tick(3'd4); tick(3'd7); tick(3'd2);
        check("ill_relock", 32'(locked), 1);

        // Break then asynchronous reset between edges
        tick(3'd0);
        check("pre_rst_seq_err", 32'(seq_err), 1);
        check("pre_rst_count", 32'(err_count), 1);
        reset = 1'b0;
        #1;
        check("arst_locked", 32'(locked), 0);
        check("arst_seq_err", 32'(seq_err), 0);
        check("arst_count", 32'(err_count), 0);
        check("arst_exp", 32'(expected), 0);
        #2 reset = 1'b1;
        tick(3'd0);
        check("post_rst_exp", 32'(expected), 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_checker.md
# seq_checker

Sequence checker for the repeating-sequence T-flip-flop counters. It samples a 3-bit counter output every enabled clock and verifies that the output follows the selected cyclic sequence: A is 0→4→7→2→3→0 and B is 0→2→4→6→0. It acquires lock after a run of consecutive correct transitions, flags every break in a locked stream and keeps a saturating error count. It sits beside the counter under test, in silicon or on a bench, as the consuming end of the counter's output.

## Interface
Parameters:
- LOCK_COUNT, 3, consecutive matching samples required to declare lock (≥1)
- ERR_W, 8, width of the error counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- sample_en  in  1  q is valid this cycle; tie high when the counter steps every clock
- q  in  3  observed counter value
- mode  in  1  0 = sequence A (0,4,7,2,3), 1 = sequence B (0,2,4,6)
- clr_err  in  1  synchronous clear of err_count
- locked  out  1  stream verified in sequence
- seq_err  out  1  one-cycle pulse on a break while locked
- err_count  out  ERR_W  number of breaks, saturating at all-ones
- expected  out  3  next value expected from q

## Operation
- Legal values:
  - Mode A: 0, 2, 3, 4 and 7. Values 1, 5 and 6 are illegal.
  - Mode B: 0, 2, 4 and 6. Odd values are illegal.
- next(v) follows the sequence table for the current mode. next() of an illegal value is 0.
- States: HUNT, VERIFY, LOCKED. The internal match_cnt is $clog2(LOCK_COUNT+1) bits wide.
- HUNT, sampled q legal: expected ← next(q), match_cnt ← 0, go to VERIFY.
- HUNT, sampled q illegal: stay in HUNT. No error is flagged.
- VERIFY, q == expected: match_cnt++ and expected ← next(q). When match_cnt reaches LOCK_COUNT, go to LOCKED and set locked = 1.
- VERIFY, mismatch: re-acquire on q. If q is legal, stay in VERIFY with match_cnt ← 0 and expected ← next(q). Otherwise go to HUNT. No seq_err is raised.
- LOCKED, q == expected: stay in LOCKED and set expected ← next(q).
- LOCKED, mismatch:
  - seq_err = 1 for one cycle, err_count increments (saturating) and locked ← 0.
  - Re-acquire as in VERIFY: go to VERIFY if q is legal, otherwise to HUNT.
- sample_en = 0: state, expected and match_cnt all hold. seq_err = 0.
- Mode change: mode is registered internally. When mode differs from its registered copy:
  - State is forced to HUNT, locked ← 0 and expected ← 0.
  - The sample in that cycle is ignored and no error is raised.
- clr_err:
  - err_count ← 0.
  - If an error increment happens in the same cycle, err_count ← 1, so the new error is not lost.
- Saturation: at all-ones, err_count holds while seq_err still pulses.

## Timing
- All outputs are registered.
- A response to the sample taken at edge k appears just after edge k.
- Lock latency: from a legal first sample, locked rises LOCK_COUNT edges after the acquiring edge. With the default, that is the 4th sampled edge after reset release.
- seq_err is high for exactly one cycle per break. Back-to-back pulses are impossible because a break always exits LOCKED.
- Reset asserted mid-operation clears immediately, independent of clk:
  - State = HUNT, locked = 0, seq_err = 0, err_count = 0, expected = 0, match_cnt = 0.
- First sampling edge after reset deassertion: reset must be released at least one setup time before that edge.

## Structure
- Shared package seq_check_pkg:
  - State encodings: HUNT = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2.
  - Mode constants: MODE_A = 1'b0, MODE_B = 1'b1.
  - Both sequence tables.
- Sub-module seq_next_lut, combinational:
  - Inputs: mode and v[2:0].
  - Outputs: nxt[2:0] and legal.
  - It is also reused by future down-counting and sequence-generator blocks.
- Top level holds the FSM, the match counter, the error counter and the mode register.

## Test plan
- Mode A, counter model stepping every clock from reset:
  - q = 0, 4, 7, 2, then 3 → locked rises after the 4th edge.
  - Over 20 further cycles: no seq_err, err_count = 0, expected is always next(q).
- Mode B locked, then force q = 2 where 6 is expected:
  - seq_err pulses once, err_count = 1 and locked = 0.
  - Stream resumes 4, 6, 0 → re-lock after 3 matches.
- Illegal stream:
  - Mode A with q = 5, 6, 1, 5 → stays in HUNT, locked = 0, no seq_err.
  - Then q = 0 → enters VERIFY with expected = 4.
- Saturation and clear, with ERR_W = 2:
  - Inject 5 breaks while re-locking each time → err_count = 3 and holds.
  - clr_err asserted in the same cycle as a break → err_count = 1.
- Mode flip while locked in mode A:
  - locked ← 0 with no seq_err and no count change.
  - Stream 0, 2, 4, 6 → locks in mode B.
- sample_en low for 3 cycles mid-lock: state holds with no error. Asynchronous reset pulse mid-lock: all outputs go to 0 immediately.
